// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN   = 64;
    localparam int N_FULL = 64;
    localparam int N_WORD = 32;
    localparam int CNT_W  = $clog2(N_FULL);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic rs1_signed(input logic [2:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring-division datapath: one quotient bit per step on unsigned magnitudes.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         word,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo_nxt,
    output logic [W-1:0] rem_nxt
);

    logic [W-1:0] quo_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] dsr_q;
    logic [W:0]   rem_sh;
    logic [W-1:0] diff;
    logic         ge;

    // The partial remainder is always below the divisor, so the difference fits in W bits.
    always_comb begin
        rem_sh  = {rem_q, quo_q[W-1]};
        ge      = rem_sh >= {1'b0, dsr_q};
        diff    = rem_sh[W-1:0] - dsr_q;
        quo_nxt = {quo_q[W-2:0], ge};
        rem_nxt = ge ? diff : rem_sh[W-1:0];
    end

    // NOTE: operand registers are reset too, so no stale operand survives a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= word ? (dividend << (W / 2)) : dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide unit with registered write-back.
// Define MULDIV_FAST_MUL_EN to compute all MUL* ops in one cycle with a combinational multiplier.
module muldiv_unit
    import muldiv_pkg::state_e, muldiv_pkg::IDLE, muldiv_pkg::CALC, muldiv_pkg::DONE,
           muldiv_pkg::OP_MUL, muldiv_pkg::OP_DIV, muldiv_pkg::OP_REM,
           muldiv_pkg::N_FULL, muldiv_pkg::N_WORD, muldiv_pkg::CNT_W,
           muldiv_pkg::rs1_signed, muldiv_pkg::rs2_signed;
#(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] p, input logic neg,
                                                   input logic [2:0] f, input logic w);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return wfix(w, (f == OP_MUL || w) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN]);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic             word_q, neg_q, rem_neg_q, load;
    logic [4:0]       rd_q, rd_cur;
    logic             s1, s2, neg_a, neg_b, div_zero, ovf;
    logic [XLEN-1:0]  a_ext, b_ext, mag_a, mag_b, most_neg, spec_res;
    logic [XLEN-1:0]  quo_nxt, rem_nxt, div_res, mul_res, res_d;

    always_comb begin
        s1       = rs1_signed(op);
        s2       = rs2_signed(op);
        a_ext    = word ? {{(XLEN-32){s1 & rs1_data[31]}}, rs1_data[31:0]} : rs1_data;
        b_ext    = word ? {{(XLEN-32){s2 & rs2_data[31]}}, rs2_data[31:0]} : rs2_data;
        neg_a    = s1 & a_ext[XLEN-1];
        neg_b    = s2 & b_ext[XLEN-1];
        mag_a    = neg_a ? -a_ext : a_ext;
        mag_b    = neg_b ? -b_ext : b_ext;
        most_neg = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = (op == OP_DIV || op == OP_REM) && (a_ext == most_neg) && (b_ext == '1);
        if (op[1]) spec_res = div_zero ? a_ext : '0;
        else       spec_res = div_zero ? '1 : a_ext;
    end

    div_iter #(.W(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (state_q == CALC && op_q[2]),
        .word     (word),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    assign div_res = wfix(word_q, op_q[1] ? (rem_neg_q ? -rem_nxt : rem_nxt)
                                          : (neg_q ? -quo_nxt : quo_nxt));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
    assign mul_res   = '0;
`else
    logic [2*XLEN-1:0] mcand_q, prod_q, prod_nxt;
    logic [XLEN-1:0]   mplier_q;

    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res  = mul_result(prod_nxt, neg_q, op_q, word_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (load) begin
            mcand_q  <= (2*XLEN)'(mag_a);
            mplier_q <= mag_b;
            prod_q   <= '0;
        end else if (state_q == CALC && !op_q[2]) begin
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`endif

    assign rd_cur = (state_q == IDLE) ? rd_addr : rd_q;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        res_d   = '0;
        case (state_q)
            IDLE: if (start) begin
                load = 1'b1;
                if (op[2] && (div_zero || ovf)) begin
                    state_d = DONE;
                    res_d   = wfix(word, spec_res);
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!op[2]) begin
                    state_d = DONE;
                    res_d   = mul_result(fast_prod, neg_a ^ neg_b, op, word);
                end
`endif
                else begin
                    state_d = CALC;
                    cnt_d   = word ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);
                end
            end
            CALC: if (cnt_q == '0) begin
                state_d = DONE;
                res_d   = op_q[2] ? div_res : mul_res;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            load    = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            wb_we   <= (state_d == DONE) && (rd_cur != 5'd0);
            wb_addr <= (state_d == DONE) ? rd_cur : '0;
            wb_data <= (state_d == DONE) ? res_d : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            word_q    <= 1'b0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (load) begin
            op_q      <= op;
            word_q    <= word;
            rd_q      <= rd_addr;
            neg_q     <= neg_a ^ neg_b;
            rem_neg_q <= neg_a;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus flush/reset/busy sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL  = 1;
    localparam int LAT_MULW = 1;
`else
    localparam int LAT_MUL  = 65;
    localparam int LAT_MULW = 33;
`endif
    localparam int LAT_DIV  = 65;
    localparam int LAT_DIVW = 33;
    localparam int LAT_SKIP = 1;
    localparam int NVEC     = 17;

    logic        clk, rst, start, word, flush;
    logic [2:0]  op;
    logic [63:0] rs1_data, rs2_data;
    logic [4:0]  rd_addr;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp_data;
        logic        exp_we;
        int          exp_lat;
    } vec_t;

    vec_t vecs[NVEC];

    muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .word     (word),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        op = f; word = w; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    endtask

    // Start one op, wait for done (bounded), capture outputs, then step into the next cycle.
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          output logic [63:0] data, output logic we, output logic [4:0] addr,
                          output int lat, output logic pulse_ok);
        @(negedge clk);
        drive(f, w, a, b, rd);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        data = wb_data; we = wb_we; addr = wb_addr;
        @(posedge clk); #1;
        pulse_ok = !done && !wb_we && !busy;
    endtask

    task automatic watch_quiet(input int cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done || wb_we) seen = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] data;
        logic        we, pulse_ok, seen;
        logic [4:0]  addr;
        int          lat;

        vecs[0]  = '{OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
                     64'hFFFF_FFFF_FFFF_FFEB, 1'b1, LAT_MUL};
        vecs[1]  = '{OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
                     64'hFFFF_FFFF_FFFF_FFFD, 1'b1, LAT_DIV};
        vecs[2]  = '{OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, LAT_DIV};
        vecs[3]  = '{OP_DIVU,   1'b0, 64'd100, 64'd0, 5'd8,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, LAT_SKIP};
        vecs[4]  = '{OP_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
                     64'd0, 1'b1, LAT_SKIP};
        vecs[5]  = '{OP_MUL,    1'b1, 64'h0000_0000_8000_0000, 64'd2, 5'd10,
                     64'd0, 1'b1, LAT_MULW};
        vecs[6]  = '{OP_DIV,    1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
                     64'hFFFF_FFFF_8000_0000, 1'b1, LAT_SKIP};
        vecs[7]  = '{OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b1, LAT_MUL};
        vecs[8]  = '{OP_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd13,
                     64'h4000_0000_0000_0000, 1'b1, LAT_MUL};
        vecs[9]  = '{OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, LAT_MUL};
        vecs[10] = '{OP_REMU,   1'b0, 64'd100, 64'd7, 5'd15,
                     64'd2, 1'b1, LAT_DIV};
        vecs[11] = '{OP_DIVU,   1'b1, 64'h1234_5678_FFFF_FFFE, 64'd2, 5'd16,
                     64'h0000_0000_7FFF_FFFF, 1'b1, LAT_DIVW};
        vecs[12] = '{OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd17,
                     64'hFFFF_FFFF_FFFF_FFFB, 1'b1, LAT_SKIP};
        vecs[13] = '{OP_MUL,    1'b0, 64'd3, 64'd4, 5'd0,
                     64'd12, 1'b0, LAT_MUL};
        vecs[14] = '{OP_DIV,    1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd18,
                     64'hFFFF_FFFF_FFFF_FFFA, 1'b1, LAT_DIV};
        vecs[15] = '{OP_REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 5'd19,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, LAT_DIVW};
        vecs[16] = '{OP_DIVU,   1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 5'd20,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, LAT_SKIP};

        rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; word = 1'b0;
        rs1_data = '0; rs2_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset wb_we", wb_we, 0);
        check("reset wb_addr", wb_addr, 0);
        check("reset wb_data", wb_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Each vector starts in the cycle right after the previous DONE.
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].rd,
                   data, we, addr, lat, pulse_ok);
            if (vecs[i].exp_we) check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d we", i), we, vecs[i].exp_we);
            check($sformatf("vec%0d addr", i), addr, vecs[i].rd);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d one-cycle pulse", i), pulse_ok, 1);
        end

        // A start while busy must be ignored.
        @(negedge clk);
        drive(OP_DIVU, 1'b0, 64'd1000, 64'd10, 5'd3);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        drive(OP_DIVU, 1'b0, 64'd100, 64'd0, 5'd9);
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy-start latency", 64'(lat), 64'(LAT_DIV));
        check("busy-start addr", wb_addr, 3);
        check("busy-start data", wb_data, 64'd100);
        @(posedge clk); #1;

        // Flush in CALC cycle 10.
        @(negedge clk);
        drive(OP_DIV, 1'b0, 64'd1000, 64'd7, 5'd13);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) @(posedge clk);
        #1;
        check("busy before flush", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("busy after flush", busy, 0);
        watch_quiet(80, seen);
        check("no writeback after flush", seen, 0);

        // Flush wins over a simultaneous start in IDLE.
        @(negedge clk);
        drive(OP_DIVU, 1'b0, 64'd100, 64'd0, 5'd14);
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("busy after flush+start", busy, 0);
        watch_quiet(10, seen);
        check("no done after flush+start", seen, 0);

        // Reset pulsed mid-CALC.
        @(negedge clk);
        drive(OP_DIV, 1'b0, 64'd3000, 64'd5, 5'd15);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset wb_we", wb_we, 0);
        check("mid reset wb_addr", wb_addr, 0);
        check("mid reset wb_data", wb_data, 0);
        @(negedge clk);
        rst = 1'b1;
        watch_quiet(80, seen);
        check("no writeback after reset", seen, 0);

        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd16, data, we, addr, lat, pulse_ok);
        check("post-reset data", data, 64'd14);
        check("post-reset we", we, 1);
        check("post-reset latency", 64'(lat), 64'(LAT_DIV));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the datapath width (only 64 is supported).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port op, input, 3 bits: funct3 encoding (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-006 SHALL have port word, input, 1 bit: RV64 *W variant (32-bit operate, sign-extend the result).
REQ-007 SHALL have ports rs1_data and rs2_data, input, XLEN bits each: the operands read from the register file.
REQ-008 SHALL have port rd_addr, input, 5 bits: the destination register.
REQ-009 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-010 SHALL have port busy, output, 1 bit: high when not in IDLE.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have ports wb_we (1 bit), wb_addr (5 bits) and wb_data (XLEN bits), outputs: the register-file write port.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE, with all outputs driven from registers.
REQ-014 SHALL capture op, word, operands and rd_addr only when start=1 in IDLE; start in any other state SHALL be ignored.
REQ-015 SHALL, for a start in cycle T with no special case, spend cycles T+1..T+N in CALC and then be in DONE at T+N+1.
  - N=64 for normal operations; N=32 when word=1.
REQ-016 SHALL assert done, wb_we, wb_addr and wb_data only in DONE, for exactly one cycle, then return to IDLE.
REQ-017 SHALL keep wb_we low whenever rd_addr==0; done still pulses in that case.
REQ-018 SHALL multiply by iterative radix-2 shift-add on magnitudes, then correct the sign.
  - Signedness: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits of the 2*XLEN product.
REQ-019 SHALL divide by iterative restoring division on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-020 SHALL return quotient all-ones and remainder = dividend on divide-by-zero, skipping CALC (DONE at T+1).
REQ-021 SHALL return quotient = dividend and remainder 0 on signed overflow (most-negative / -1, at the active width), skipping CALC (DONE at T+1).
REQ-022 SHALL, when word=1, use only bits [31:0] of each operand and sign-extend result bit 31 into wb_data[63:32].
REQ-023 SHALL, on flush=1, enter IDLE next cycle with no write-back from any state; flush SHALL take priority over a simultaneous start.
REQ-024 SHALL accept a start in the cycle immediately after DONE (back-to-back operations).

Reset
REQ-025 SHALL, while rst=0, force the state to IDLE and busy, done, wb_we, wb_addr and wb_data to 0, and clear all internal counters and operand registers.
REQ-026 SHALL drop busy immediately on reset asserted mid-operation, and produce no write-back after reset is released.

Configuration
REQ-027 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute all MUL* ops with a single-cycle combinational multiplier and go from IDLE directly to DONE (DONE at T+1); divides are unchanged.
REQ-028 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiplier of REQ-015 and REQ-018.

Structure
REQ-029 SHALL place XLEN, the op encodings, the FSM state typedef and the iteration counts N in the shared package muldiv_pkg.
REQ-030 SHALL implement the restoring-division datapath (remainder/quotient shift registers and the iteration step) as the sub-module div_iter, instantiated once.

Verification
REQ-031 SHALL cover: MUL rs1=7, rs2=-3, rd=5 -> done exactly 65 cycles after start; wb_we=1, wb_addr=5, wb_data=0xFFFF_FFFF_FFFF_FFEB.
REQ-032 SHALL cover: DIV rs1=-7, rs2=2 -> quotient 0xFFFF_FFFF_FFFF_FFFD; REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-033 SHALL cover: DIVU rs1=100, rs2=0 -> done at T+1 with wb_data all-ones; REM rs1=0x8000_0000_0000_0000, rs2=-1 -> done at T+1 with wb_data 0.
REQ-034 SHALL cover: MULW rs1=0x0000_0000_8000_0000, rs2=2 -> done 33 cycles after start, wb_data 0.
  - DIVW rs1=0xFFFF_FFFF_8000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF -> wb_data 0xFFFF_FFFF_8000_0000.
REQ-035 SHALL cover: flush in CALC cycle 10 -> busy=0 next cycle and wb_we never asserted; a start on a flush cycle is ignored.
  - Reset pulsed mid-CALC -> all outputs 0 immediately.
REQ-036 SHALL cover: rd_addr=0 -> done pulses with wb_we=0.
  - A start during busy is ignored, and a new start in the cycle after DONE is accepted.
